// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: H/V counters, sync/DE decode, run/stop FSM and frame-boundary request latching.
// Optional feature macro VGA_TIMING_FRAME_CNT_EN adds the 16-bit oFRAME_CNT output.
module vga_timing_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int HACTIVE    = 640,
    parameter int HFP        = 16,
    parameter int HSYNC      = 96,
    parameter int HBP        = 48,
    parameter int VACTIVE    = 480,
    parameter int VFP        = 10,
    parameter int VSYNC      = 2,
    parameter int VBP        = 33,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                  VCLK,
    input  logic                  RST,
    input  logic                  iEN,
    input  logic                  iMODE_REQ,
    input  logic [ADDR_WIDTH-1:0] iPOINT_X_REQ,
    input  logic [ADDR_WIDTH-1:0] iPOINT_Y_REQ,
    output logic                  oHSYNC,
    output logic                  oVSYNC,
    output logic                  oDE,
    output logic [ADDR_WIDTH-1:0] oH_ADDR,
    output logic [ADDR_WIDTH-1:0] oV_ADDR,
    output logic                  oMODE,
    output logic [ADDR_WIDTH-1:0] oPOINT_X,
    output logic [ADDR_WIDTH-1:0] oPOINT_Y,
    output logic                  oFRAME_START,
    output logic                  oVBLANK_START,
    output logic                  oBUSY
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]           oFRAME_CNT
`endif
);
    localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
    localparam logic [ADDR_WIDTH-1:0] L_H_LAST  = ADDR_WIDTH'(HTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] L_V_LAST  = ADDR_WIDTH'(VTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] L_HACT    = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] L_VACT    = ADDR_WIDTH'(VACTIVE);
    localparam logic [ADDR_WIDTH-1:0] L_HS_BEG  = ADDR_WIDTH'(HACTIVE + HFP);
    localparam logic [ADDR_WIDTH-1:0] L_HS_END  = ADDR_WIDTH'(HACTIVE + HFP + HSYNC);
    localparam logic [ADDR_WIDTH-1:0] L_VS_BEG  = ADDR_WIDTH'(VACTIVE + VFP);
    localparam logic [ADDR_WIDTH-1:0] L_VS_END  = ADDR_WIDTH'(VACTIVE + VFP + VSYNC);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_h;
    logic [ADDR_WIDTH-1:0]   r_v;
    logic [ADDR_WIDTH-1:0]   w_h_inc;
    logic [ADDR_WIDTH-1:0]   w_v_inc;
    logic [ADDR_WIDTH-1:0]   w_h_nxt;
    logic [ADDR_WIDTH-1:0]   w_v_nxt;
    logic                    w_last;
    logic                    w_latch;
    logic                    w_scan;
    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_de;
    logic                    r_frame_start;
    logic                    r_vblank_start;
    logic                    r_busy;
    logic                    r_mode;
    logic [ADDR_WIDTH-1:0]   r_point_x;
    logic [ADDR_WIDTH-1:0]   r_point_y;

    always_comb begin
        w_last  = (r_h == L_H_LAST) && (r_v == L_V_LAST);
        w_h_inc = (r_h == L_H_LAST) ? '0 : r_h + ADDR_WIDTH'(1);
        w_v_inc = r_v;
        if (r_h == L_H_LAST) begin
            w_v_inc = (r_v == L_V_LAST) ? '0 : r_v + ADDR_WIDTH'(1);
        end

        w_state_nxt = r_state;
        w_h_nxt     = w_h_inc;
        w_v_nxt     = w_v_inc;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (iEN) begin
                    w_state_nxt = S_RUN;
                    w_latch     = 1'b1;
                end
            end
            S_RUN: begin
                if (!iEN) begin
                    w_state_nxt = S_STOPPING;
                end
                w_latch = w_last;
            end
            S_STOPPING: begin
                // Stop only once the frame in flight has been fully scanned.
                if (iEN) begin
                    w_state_nxt = S_RUN;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
                w_latch = w_last && iEN;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_h_nxt     = '0;
                w_v_nxt     = '0;
            end
        endcase
        w_scan = (w_state_nxt != S_IDLE);
    end

    // Decode from next-counter values so every output lines up with the counters.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_h            <= '0;
            r_v            <= '0;
            r_hsync        <= ~SYNC_POL;
            r_vsync        <= ~SYNC_POL;
            r_de           <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
            r_busy         <= 1'b0;
            r_mode         <= 1'b0;
            r_point_x      <= '0;
            r_point_y      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_h            <= w_h_nxt;
            r_v            <= w_v_nxt;
            r_hsync        <= (w_scan && (w_h_nxt >= L_HS_BEG) && (w_h_nxt < L_HS_END)) ? SYNC_POL : ~SYNC_POL;
            r_vsync        <= (w_scan && (w_v_nxt >= L_VS_BEG) && (w_v_nxt < L_VS_END)) ? SYNC_POL : ~SYNC_POL;
            r_de           <= w_scan && (w_h_nxt < L_HACT) && (w_v_nxt < L_VACT);
            r_frame_start  <= w_latch;
            r_vblank_start <= w_scan && (w_h_nxt == '0) && (w_v_nxt == L_VACT);
            r_busy         <= w_scan;
            if (w_latch) begin
                r_mode    <= iMODE_REQ;
                r_point_x <= iPOINT_X_REQ;
                r_point_y <= iPOINT_Y_REQ;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // The frame start that leaves IDLE is not counted; only wraps are.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            r_frame_cnt <= '0;
        end else if (w_latch && (r_state != S_IDLE)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign oFRAME_CNT = r_frame_cnt;
`endif

    assign oHSYNC        = r_hsync;
    assign oVSYNC        = r_vsync;
    assign oDE           = r_de;
    assign oH_ADDR       = r_h;
    assign oV_ADDR       = r_v;
    assign oMODE         = r_mode;
    assign oPOINT_X      = r_point_x;
    assign oPOINT_Y      = r_point_y;
    assign oFRAME_START  = r_frame_start;
    assign oVBLANK_START = r_vblank_start;
    assign oBUSY         = r_busy;
endmodule
